// File: rtl/kt_lowx_line_fetcher_if.sv
// Bundle for the fetcher: lowX line request/response on the cache side and
// in-order beat read port on the memory side. slave = fetcher, master = environment.
interface kt_lowx_line_fetcher_if #(
  parameter int XLEN     = 32,
  parameter int BLK_SIZE = 128
);
  logic                lowx_req_valid_i;
  logic                lowx_req_ready_o;
  logic [XLEN-1:0]     lowx_req_addr_i;
  logic                lowx_res_valid_o;
  logic                lowx_res_ready_i;
  logic [BLK_SIZE-1:0] lowx_res_blk_o;
  logic                lowx_res_err_o;
  logic                mem_req_valid_o;
  logic                mem_req_ready_i;
  logic [XLEN-1:0]     mem_req_addr_o;
  logic                mem_rsp_valid_i;
  logic [XLEN-1:0]     mem_rsp_data_i;
  logic                mem_rsp_err_i;

  modport slave (
    input  lowx_req_valid_i, lowx_req_addr_i, lowx_res_ready_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_err_i,
    output lowx_req_ready_o, lowx_res_valid_o, lowx_res_blk_o, lowx_res_err_o,
           mem_req_valid_o, mem_req_addr_o
  );

  modport master (
    output lowx_req_valid_i, lowx_req_addr_i, lowx_res_ready_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_err_i,
    input  lowx_req_ready_o, lowx_res_valid_o, lowx_res_blk_o, lowx_res_err_o,
           mem_req_valid_o, mem_req_addr_o
  );
endinterface

// File: rtl/kt_lowx_line_fetcher.sv
// Line-fill engine: splits a lowX miss into BEATS word reads and reassembles the line.
// KT_LINE_FETCH_CRIT_FIRST_EN: issue beats critical-word-first in wrap order.
module kt_lowx_line_fetcher #(
  parameter int XLEN     = 32,
  parameter int BLK_SIZE = 128
) (
  input logic                  clk_i,
  input logic                  rst_i,
  kt_lowx_line_fetcher_if.slave bus
);
  localparam int BEATS = BLK_SIZE / XLEN;
  localparam int BW    = $clog2(BEATS);
  localparam int CW    = BW + 1;
  localparam int WB    = $clog2(XLEN / 8);
  localparam int OFFB  = $clog2(BLK_SIZE / 8);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]                 r_state;
  logic [XLEN-1:0]            r_base;
  logic [BW-1:0]              r_start;
  logic [CW-1:0]              r_issue;
  logic [CW-1:0]              r_rcv;
  logic                       r_err;
  logic [BEATS-1:0][XLEN-1:0] r_blk;

  logic [BW-1:0]   w_start;
  logic [BW-1:0]   w_iss_slot;
  logic [BW-1:0]   w_rcv_slot;
  logic [XLEN-1:0] w_base;
  logic            w_req_fire;
  logic            w_rsp_fire;
  logic            w_unused;

`ifdef KT_LINE_FETCH_CRIT_FIRST_EN
  assign w_start = bus.lowx_req_addr_i[OFFB-1:WB];
`else
  assign w_start = '0;
`endif

  assign w_base     = {bus.lowx_req_addr_i[XLEN-1:OFFB], {OFFB{1'b0}}};
  assign w_iss_slot = r_start + r_issue[BW-1:0];
  assign w_rcv_slot = r_start + r_rcv[BW-1:0];
  assign w_req_fire = bus.mem_req_valid_o && bus.mem_req_ready_i;
  // Responses outside FETCH (or beyond a full line) are protocol violations: drop them.
  assign w_rsp_fire = (r_state == S_FETCH) && bus.mem_rsp_valid_i && !r_rcv[BW];
  assign w_unused   = ^bus.lowx_req_addr_i[OFFB-1:0];

  assign bus.lowx_req_ready_o = (r_state == S_IDLE);
  assign bus.lowx_res_valid_o = (r_state == S_RESP);
  assign bus.mem_req_valid_o  = (r_state == S_FETCH) && !r_issue[BW];
  assign bus.mem_req_addr_o   = r_base + (XLEN'(w_iss_slot) << WB);
  assign bus.lowx_res_blk_o   = r_blk;
  assign bus.lowx_res_err_o   = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_start <= '0;
      r_issue <= '0;
      r_rcv   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.lowx_req_valid_i) begin
          r_base  <= w_base;
          r_start <= w_start;
          r_issue <= '0;
          r_rcv   <= '0;
          r_err   <= 1'b0;
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (w_req_fire) r_issue <= r_issue + 1'b1;
          if (w_rsp_fire) begin
            r_err <= r_err | bus.mem_rsp_err_i;
            r_rcv <= r_rcv + 1'b1;
            if (r_rcv == CW'(BEATS - 1)) r_state <= S_RESP;
          end
        end
        S_RESP: if (bus.lowx_res_ready_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Each beat lands in its natural slot regardless of issue order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           r_blk             <= '0;
    else if (w_rsp_fire) r_blk[w_rcv_slot] <= bus.mem_rsp_data_i;
  end
endmodule
